parking_occupancy: RTL

Multi-lane bidirectional vehicle counter for the parking-meter design. Each lane has two presence sensors, outer (a) and inner (b). A per-lane sequence detector recognises complete entries (a → ab → b → none) and exits (b → ab → a → none). A shared saturating occupancy counter tracks cars inside against a configurable capacity and exposes full/empty flags, wrapping entry/exit totals and sticky error flags to the display/decimal stage.

---
 rtl/parking_pkg.sv | 19 +
 rtl/lane_dir_fsm.sv | 105 ++++++++++
 rtl/parking_occupancy.sv | 93 +++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared lane-state encoding and default sizing for the parking occupancy counter.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        IN1  = 3'b001,
        IN2  = 3'b010,
        IN3  = 3'b011,
        OUT1 = 3'b101,
        OUT2 = 3'b110,
        OUT3 = 3'b111
    } lane_state_t;

    localparam int DEF_NLANES   = 2;
    localparam int DEF_CAPACITY = 100;
    localparam int DEF_CW       = 8;
    localparam int DEF_TW       = 13;

endpackage

// File: rtl/lane_dir_fsm.sv
// Per-lane crossing detector: recognises a full entry or exit from the two presence sensors.
//
// state | meaning
// IDLE  | lane clear, waiting for the first sensor
// IN1   | outer sensor only (entry started)
// IN2   | both sensors (entry in progress)
// IN3   | inner sensor only (entry about to complete)
// OUT1  | inner sensor only (exit started)
// OUT2  | both sensors (exit in progress)
// OUT3  | outer sensor only (exit about to complete)
module lane_dir_fsm
    import parking_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic in_evt,
    output logic out_evt
);

    lane_state_t state, state_nxt;
    logic        in_nxt, out_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            in_evt  <= 1'b0;
            out_evt <= 1'b0;
        end else begin
            state   <= state_nxt;
            in_evt  <= in_nxt;
            out_evt <= out_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        in_nxt    = 1'b0;
        out_nxt   = 1'b0;
        case (state)
            IDLE: begin
                case ({a, b})
                    2'b10:   state_nxt = IN1;
                    2'b01:   state_nxt = OUT1;
                    default: state_nxt = IDLE;
                endcase
            end
            IN1: begin
                case ({a, b})
                    2'b11:   state_nxt = IN2;
                    2'b10:   state_nxt = IN1;
                    default: state_nxt = IDLE;
                endcase
            end
            IN2: begin
                case ({a, b})
                    2'b01:   state_nxt = IN3;
                    2'b10:   state_nxt = IN1;
                    2'b11:   state_nxt = IN2;
                    default: state_nxt = IDLE;
                endcase
            end
            IN3: begin
                case ({a, b})
                    2'b00: begin
                        state_nxt = IDLE;
                        in_nxt    = 1'b1;
                    end
                    2'b11:   state_nxt = IN2;
                    2'b01:   state_nxt = IN3;
                    default: state_nxt = IDLE;
                endcase
            end
            OUT1: begin
                case ({a, b})
                    2'b11:   state_nxt = OUT2;
                    2'b01:   state_nxt = OUT1;
                    default: state_nxt = IDLE;
                endcase
            end
            OUT2: begin
                case ({a, b})
                    2'b10:   state_nxt = OUT3;
                    2'b01:   state_nxt = OUT1;
                    2'b11:   state_nxt = OUT2;
                    default: state_nxt = IDLE;
                endcase
            end
            OUT3: begin
                case ({a, b})
                    2'b00: begin
                        state_nxt = IDLE;
                        out_nxt   = 1'b1;
                    end
                    2'b11:   state_nxt = OUT2;
                    2'b10:   state_nxt = OUT3;
                    default: state_nxt = IDLE;
                endcase
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/parking_occupancy.sv
// Multi-lane vehicle counter: nets lane events into a saturating occupancy count,
// wrapping entry/exit totals and sticky over/underflow flags.
module parking_occupancy
    import parking_pkg::*;
#(
    parameter int NLANES   = DEF_NLANES,
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int CW       = DEF_CW,
    parameter int TW       = DEF_TW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              syn_clr,
    input  logic [NLANES-1:0] lane_a,
    input  logic [NLANES-1:0] lane_b,
    output logic [CW-1:0]     occupancy,
    output logic              full,
    output logic              empty,
    output logic [TW-1:0]     entry_total,
    output logic [TW-1:0]     exit_total,
    output logic              overflow,
    output logic              underflow,
    output logic [NLANES-1:0] lane_in_evt,
    output logic [NLANES-1:0] lane_out_evt
);

    localparam int SW = CW + 2;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    logic [SW-1:0]        sum_in, sum_out;
    logic signed [SW-1:0] t;
    logic [CW-1:0]        occ_nxt;
    logic                 ovf_hit, unf_hit;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        lane_dir_fsm u_lane (
            .clk     (clk),
            .reset   (reset),
            .a       (lane_a[i]),
            .b       (lane_b[i]),
            .in_evt  (lane_in_evt[i]),
            .out_evt (lane_out_evt[i])
        );
    end

    always_comb begin
        sum_in  = '0;
        sum_out = '0;
        for (int i = 0; i < NLANES; i++) begin
            sum_in  = sum_in  + SW'(lane_in_evt[i]);
            sum_out = sum_out + SW'(lane_out_evt[i]);
        end
    end

    // Entries and exits are netted first so simultaneous crossings cancel before clamping.
    always_comb begin
        t       = $signed({2'b00, occupancy}) + $signed(sum_in) - $signed(sum_out);
        ovf_hit = (t > CAP_S);
        unf_hit = (t < 0);
        if (unf_hit)
            occ_nxt = '0;
        else if (ovf_hit)
            occ_nxt = CW'(CAPACITY);
        else
            occ_nxt = t[CW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy   <= '0;
            entry_total <= '0;
            exit_total  <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (syn_clr) begin
            occupancy   <= '0;
            entry_total <= '0;
            exit_total  <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            occupancy   <= occ_nxt;
            entry_total <= entry_total + TW'(sum_in);
            exit_total  <= exit_total + TW'(sum_out);
            overflow    <= overflow | ovf_hit;
            underflow   <= underflow | unf_hit;
        end
    end

    assign full  = (occupancy == CW'(CAPACITY));
    assign empty = (occupancy == '0);

endmodule
